// File: rtl/ballot_collector.sv
// Four-voter ballot front end: sync, debounce, timed window, ballot emit.
// Define BALLOT_EARLY_CLOSE_EN to close the window as soon as all four lock.
module ballot_collector #(
    parameter int DEB_CYCLES    = 4,
    parameter int WINDOW_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] vote_in,
    output logic [3:0] I,
    output logic       ballot_valid,
    output logic       busy,
    output logic [3:0] locked
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(WINDOW_CYCLES);

    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        EMIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] cnt [4];
    logic [WW-1:0] win;
    logic [3:0]    lock_hit;
    logic [3:0]    locked_nx;
    logic          open_entry;
    logic          emit_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= vote_in;
            sync2 <= sync1;
        end
    end

    // Counters keep running outside OPEN; only the lock update is gated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n || open_entry || !sync2[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] != DEB_MAX) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        lock_hit = '0;
        for (int i = 0; i < 4; i++) begin
            lock_hit[i] = (cnt[i] == DEB_MAX);
        end
    end

    always_comb begin
        locked_nx = locked;
        if (open_entry) begin
            locked_nx = '0;
        end else if (state == OPEN) begin
            locked_nx = locked | lock_hit;
        end
    end

    always_comb begin
        state_nx   = state;
        open_entry = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = OPEN;
                    open_entry = 1'b1;
                end
            end
            OPEN: begin
                if (win == WIN_LAST) begin
                    state_nx = EMIT;
                end
`ifdef BALLOT_EARLY_CLOSE_EN
                else if (locked == 4'b1111) begin
                    state_nx = EMIT;
                end
`endif
            end
            EMIT: begin
                state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx   = OPEN;
                    open_entry = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign emit_entry = (state == OPEN) && (state_nx == EMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || open_entry) begin
            win <= '0;
        end else if (state == OPEN && win != WIN_LAST) begin
            win <= win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked <= '0;
        end else begin
            locked <= locked_nx;
        end
    end

    // Ballot sees a lock that completes on the closing edge itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            I <= '0;
        end else if (emit_entry) begin
            I <= locked_nx;
        end
    end

    assign ballot_valid = (state == EMIT);
    assign busy         = (state == OPEN) || (state == EMIT);

endmodule

// File: tb/tb_ballot_collector.sv
// Directed vector bench for ballot_collector at default parameters.
module tb_ballot_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] vote_in;
    logic [3:0] I;
    logic       ballot_valid;
    logic       busy;
    logic [3:0] locked;

    int checks = 0;
    int errors = 0;

`ifdef BALLOT_EARLY_CLOSE_EN
    localparam int ALL_EMIT = 7;
`else
    localparam int ALL_EMIT = 64;
`endif

    typedef struct {
        logic [3:0] hold;
        logic [3:0] p_mask;
        int         p_start;
        int         p_len;
        logic [3:0] exp_i;
        int         exp_emit;
    } vec_t;

    vec_t tbl [8];

    ballot_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vote_in      (vote_in),
        .I            (I),
        .ballot_valid (ballot_valid),
        .busy         (busy),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vote_at(input vec_t v, input int j);
        logic [3:0] p;
        p = (j >= v.p_start && j < v.p_start + v.p_len) ? v.p_mask : 4'h0;
        return v.hold | p;
    endfunction

    initial begin
        logic [3:0] prev_i;
        logic [3:0] i_emit;
        int         n_valid;
        int         emit_at;

        tbl[0] = '{4'b0101, 4'b0000,  0,  0, 4'b0101, 64};
        tbl[1] = '{4'b0001, 4'b1000,  3,  3, 4'b0001, 64};
        tbl[2] = '{4'b0000, 4'b0010,  2, 11, 4'b0010, 64};
        tbl[3] = '{4'b1111, 4'b0000,  0,  0, 4'b1111, ALL_EMIT};
        tbl[4] = '{4'b0000, 4'b0000,  0,  0, 4'b0000, 64};
        tbl[5] = '{4'b0000, 4'b0100, 10,  4, 4'b0100, 64};
        tbl[6] = '{4'b0000, 4'b1000, 58,  6, 4'b1000, 64};
        tbl[7] = '{4'b0000, 4'b1000, 59,  6, 4'b0000, 64};

        rst_n   = 1'b0;
        start   = 1'b1;
        vote_in = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            check("rst_I", I, 4'h0);
            check("rst_valid", ballot_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_locked", locked, 4'h0);
        end
        rst_n   = 1'b1;
        start   = 1'b0;
        vote_in = 4'h0;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        prev_i = 4'h0;
        for (int r = 0; r < 8; r++) begin
            vote_in = 4'h0;
            start   = 1'b0;
            repeat (4) @(negedge clk);
            n_valid = 0;
            emit_at = -1;
            i_emit  = 4'h0;
            for (int j = 0; j <= 70; j++) begin
                start   = (j == 0);
                vote_in = vote_at(tbl[r], j);
                @(negedge clk);
                if (j == 0) check($sformatf("v%0d_busy", r), busy, 1'b1);
                if (j == 5) check($sformatf("v%0d_I_kept", r), I, prev_i);
                if (r == 0 && j == 5) check("lock_t5", locked, 4'b0000);
                if (r == 0 && j == 6) check("lock_t6", locked, 4'b0101);
                if (ballot_valid) begin
                    n_valid++;
                    if (emit_at < 0) begin
                        emit_at = j;
                        i_emit  = I;
                    end
                end
            end
            check($sformatf("v%0d_nvalid", r), n_valid, 1);
            check($sformatf("v%0d_emit_at", r), emit_at, tbl[r].exp_emit);
            check($sformatf("v%0d_I_emit", r), i_emit, tbl[r].exp_i);
            check($sformatf("v%0d_I_hold", r), I, tbl[r].exp_i);
            check($sformatf("v%0d_locked", r), locked, tbl[r].exp_i);
            check($sformatf("v%0d_done_busy", r), busy, 1'b0);
            prev_i = tbl[r].exp_i;
        end

        // start held across EMIT, then re-pulsed mid-window
        vote_in = 4'h0;
        start   = 1'b0;
        repeat (4) @(negedge clk);
        n_valid = 0;
        for (int j = 0; j <= 132; j++) begin
            start   = (j <= 66) || (j == 76);
            vote_in = 4'b0011;
            @(negedge clk);
            if (ballot_valid) n_valid++;
            if (j == 64) begin
                check("held_valid64", ballot_valid, 1'b1);
                check("held_I64", I, 4'b0011);
            end
            if (j == 65) begin
                check("held_done_busy", busy, 1'b0);
                check("held_done_valid", ballot_valid, 1'b0);
            end
            if (j == 66) check("held_reopen", busy, 1'b1);
            if (j == 130) check("repulse_valid130", ballot_valid, 1'b1);
        end
        check("repulse_nvalid", n_valid, 2);

        // reset in the middle of a window
        vote_in = 4'h0;
        start   = 1'b0;
        repeat (4) @(negedge clk);
        n_valid = 0;
        for (int j = 0; j <= 90; j++) begin
            start   = (j == 0);
            rst_n   = !(j == 20 || j == 21);
            vote_in = 4'b0110;
            @(negedge clk);
            if (ballot_valid) n_valid++;
            if (j == 19) check("mid_I_kept", I, 4'b0011);
            if (j == 19) check("mid_locked", locked, 4'b0110);
            if (j == 20) begin
                check("mid_rst_I", I, 4'h0);
                check("mid_rst_busy", busy, 1'b0);
                check("mid_rst_locked", locked, 4'h0);
            end
        end
        rst_n = 1'b1;
        check("mid_rst_nvalid", n_valid, 0);
        check("mid_rst_I_end", I, 4'h0);
        check("mid_rst_busy_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
